// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if
//  Buffer-side bus of the ADC capture sequencer: write strobe/address/select
//  toward the ping-pong buffer RAMs plus the host read-ownership handshake.
//  Signals:
//    buf_wr_en    write strobe to buffer buf_wr_sel (1-clk pulse)
//    buf_wr_addr  write address, valid with buf_wr_en
//    buf_wr_sel   buffer currently being written
//    rd_sel       buffer the host reads, always ~buf_wr_sel
//    ready        a completed, unread frame sits in rd_sel
//    host_lock    host is reading the rd_sel buffer
//  Modports: master = sequencer, slave = buffer/register-file side.
interface capture_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              buf_wr_sel;
  logic              rd_sel;
  logic              ready;
  logic              host_lock;

  modport master (
    output buf_wr_en, buf_wr_addr, buf_wr_sel, rd_sel, ready,
    input  host_lock
  );

  modport slave (
    input  buf_wr_en, buf_wr_addr, buf_wr_sel, rd_sel, ready,
    output host_lock
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl
//  Sequencer for the ping-pong ADC capture buffer. Arms on a comparator edge,
//  issues decimated write strobes/addresses, swaps buffers on frame
//  completion and arbitrates buffer ownership against the host read lock.
//  Ports:
//    clk, rst_n    system clock, asynchronous active-low reset
//    sample_vld    one-clk strobe per ADC sample (clk domain)
//    stable        front end stable; capture allowed only while 1
//    signal_in     asynchronous comparator input (2-FF synchronized here)
//    cfg_enable    continuous capture enable
//    cfg_edge      trigger edge: 0 rising, 1 falling
//    cfg_decim     keep 1 of (cfg_decim+1) samples
//    cfg_holdoff   sample strobes to wait after a frame before re-arming
//    ovr_clr       one-clk pulse clearing overrun
//    overrun       sticky: frame dropped or unread frame overwritten
//    frame_cnt     completed (swapped) frames, wraps
//    state_o       0 IDLE, 1 ARMED, 2 CAPTURE, 3 HOLDOFF
//    bus           buffer write / host handshake (master side)
module capture_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DECIM_W   = 8,
  parameter int HOLDOFF_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_vld,
  input  logic                 stable,
  input  logic                 signal_in,
  input  logic                 cfg_enable,
  input  logic                 cfg_edge,
  input  logic [DECIM_W-1:0]   cfg_decim,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  input  logic                 ovr_clr,
  output logic                 overrun,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [1:0]           state_o,
  capture_ctrl_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t               state, state_nx;
  logic                 sig_s1, sig_s2, sig_q;
  logic                 trig;
  logic                 run_ok;
  logic                 wr_go;
  logic [ADDR_W-1:0]    addr;
  logic [DECIM_W-1:0]   decim_cnt;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 wr_en_p1;
  logic [ADDR_W-1:0]    wr_addr_p1;
  logic                 wr_sel;
  logic                 ready_r;
  logic                 host_lock_q;
  logic                 frame_done;
  logic                 swap;
  logic                 lock_fall;

  assign run_ok = cfg_enable & stable;

  // sig_s2 vs sig_q gives the edge one clk after the synchronizer, so the
  // FSM reacts on the third clk after the pin change.
  assign trig = cfg_edge ? (~sig_s2 & sig_q) : (sig_s2 & ~sig_q);

  // Completion is acted on the cycle after the last write strobe so the
  // buffer select is still stable while that final write lands.
  assign frame_done = wr_en_p1 & (wr_addr_p1 == LAST_ADDR);
  assign swap       = frame_done & ~bus.host_lock;
  assign lock_fall  = host_lock_q & ~bus.host_lock;

  always_comb begin
    state_nx = state;
    wr_go    = 1'b0;
    case (state)
      IDLE: begin
        if (run_ok) state_nx = ARMED;
      end
      ARMED: begin
        if (!run_ok)   state_nx = IDLE;
        else if (trig) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (!run_ok) begin
          state_nx = IDLE;
        end else if (sample_vld && (decim_cnt == '0)) begin
          wr_go = 1'b1;
          if (addr == LAST_ADDR) state_nx = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (!run_ok)                       state_nx = IDLE;
        else if (hold_cnt == cfg_holdoff)  state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0 -> p1: state, counters, registered write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sig_s1     <= 1'b0;
      sig_s2     <= 1'b0;
      sig_q      <= 1'b0;
      addr       <= '0;
      decim_cnt  <= '0;
      hold_cnt   <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
    end else begin
      state    <= state_nx;
      sig_s1   <= signal_in;
      sig_s2   <= sig_s1;
      sig_q    <= sig_s2;
      wr_en_p1 <= wr_go;
      if (wr_go) wr_addr_p1 <= addr;

      if (state == ARMED && state_nx == CAPTURE) begin
        addr      <= '0;
        decim_cnt <= '0;
      end else if (state == CAPTURE && run_ok && sample_vld) begin
        decim_cnt <= (decim_cnt == cfg_decim) ? '0 : decim_cnt + DECIM_W'(1);
        if (decim_cnt == '0) addr <= addr + ADDR_W'(1);
      end
      if (state_nx == IDLE) addr <= '0;

      if (state != HOLDOFF)  hold_cnt <= '0;
      else if (sample_vld)   hold_cnt <= hold_cnt + HOLDOFF_W'(1);
    end
  end

  // Stage p1 -> p2: buffer swap, ready/overrun flags, frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel      <= 1'b0;
      ready_r     <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= '0;
      host_lock_q <= 1'b0;
    end else begin
      host_lock_q <= bus.host_lock;
      if (swap) begin
        wr_sel    <= ~wr_sel;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      // A completion coincident with the lock release still sets ready.
      if (swap)           ready_r <= 1'b1;
      else if (lock_fall) ready_r <= 1'b0;
      // Dropped frame (locked) or recycled unread frame; set beats clear.
      if (frame_done && (bus.host_lock || ready_r)) overrun <= 1'b1;
      else if (ovr_clr)                             overrun <= 1'b0;
    end
  end

  assign bus.buf_wr_en   = wr_en_p1;
  assign bus.buf_wr_addr = wr_addr_p1;
  assign bus.buf_wr_sel  = wr_sel;
  assign bus.rd_sel      = ~wr_sel;
  assign bus.ready       = ready_r;
  assign state_o         = state;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl
//  Scoreboard bench for capture_ctrl: expected write addresses are queued as
//  sample strobes are driven and popped when buf_wr_en appears.
module tb_capture_ctrl;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_vld = 1'b0;
  logic        stable = 1'b0;
  logic        signal_in = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_edge = 1'b0;
  logic [7:0]  cfg_decim = '0;
  logic [15:0] cfg_holdoff = '0;
  logic        ovr_clr = 1'b0;
  logic        overrun;
  logic [15:0] frame_cnt;
  logic [1:0]  state_o;

  capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  capture_ctrl #(.ADDR_W(ADDR_W), .DECIM_W(8), .HOLDOFF_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_vld(sample_vld), .stable(stable),
    .signal_in(signal_in), .cfg_enable(cfg_enable), .cfg_edge(cfg_edge),
    .cfg_decim(cfg_decim), .cfg_holdoff(cfg_holdoff), .ovr_clr(ovr_clr),
    .overrun(overrun), .frame_cnt(frame_cnt), .state_o(state_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  bit cap_on = 1'b0;
  int m_idx = 0;
  int m_dec = 0;
  logic vld_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample strobe followed by one idle clk; pushes the expected write.
  task automatic strobe(input bit drop_lock, input bit clr);
    sample_vld = 1'b1;
    if (cap_on) begin
      if (m_idx % (m_dec + 1) == 0) begin
        exp_q.push_back(m_idx / (m_dec + 1));
        if (m_idx / (m_dec + 1) == 1023) cap_on = 1'b0;
      end
      m_idx++;
    end
    tick();
    sample_vld = 1'b0;
    if (drop_lock) bus.host_lock = 1'b0;
    if (clr) ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe(1'b0, 1'b0);
  endtask

  // Low then high on the comparator: the fall must be ignored, the rise
  // must move ARMED -> CAPTURE exactly on the third clk.
  task automatic trigger();
    signal_in = 1'b0;
    repeat (4) tick();
    check("fall_ignored", state_o, 1);
    signal_in = 1'b1;
    tick(); tick();
    check("trig_lat2", state_o, 1);
    tick();
    check("trig_lat3", state_o, 2);
    cap_on = 1'b1;
    m_idx = 0;
  endtask

  task automatic flags(input string tag, input int sel, input int rdy, input int ovr, input int cnt);
    check({tag, "_wsel"}, bus.buf_wr_sel, sel);
    check({tag, "_rsel"}, bus.rd_sel, 1 - sel);
    check({tag, "_ready"}, bus.ready, rdy);
    check({tag, "_ovr"}, overrun, ovr);
    check({tag, "_cnt"}, frame_cnt, cnt);
  endtask

  always @(posedge clk) vld_prev <= sample_vld;

  always @(negedge clk) begin
    if (rst_n && bus.buf_wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", bus.buf_wr_addr, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", bus.buf_wr_addr, exp_q.pop_front());
        check("wr_lat", vld_prev, 1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.host_lock = 1'b0;
    tick(); tick();
    check("rst_state", state_o, 0);
    check("rst_wr_en", bus.buf_wr_en, 0);
    check("rst_addr", bus.buf_wr_addr, 0);
    flags("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    stable = 1'b1;
    tick();
    check("arm", state_o, 1);

    // T1: reset in the middle of a capture
    trigger();
    strobes(500);
    check("t1_pending", exp_q.size(), 0);
    cap_on = 1'b0;
    rst_n = 1'b0;
    signal_in = 1'b0;
    tick(); tick();
    check("t1_state", state_o, 0);
    check("t1_wr_en", bus.buf_wr_en, 0);
    check("t1_addr", bus.buf_wr_addr, 0);
    flags("t1", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("t1_rearm", state_o, 1);

    // T2: every sample written, first swap
    trigger();
    strobes(1024);
    check("t2_pending", exp_q.size(), 0);
    check("t2_state", state_o, 1);
    flags("t2", 1, 1, 0, 1);

    // Lock release clears ready, rd_sel unchanged
    bus.host_lock = 1'b1; tick();
    bus.host_lock = 1'b0; tick();
    flags("clr", 1, 0, 0, 1);

    // T3: decimate by 4
    cfg_decim = 8'd3; m_dec = 3;
    trigger();
    strobes(4096);
    check("t3_pending", exp_q.size(), 0);
    flags("t3", 0, 1, 0, 2);
    cfg_decim = 8'd0; m_dec = 0;

    // T5: second unread frame recycles the buffer
    trigger();
    strobes(1024);
    flags("t5", 1, 1, 1, 3);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();
    check("t5_ovr_clr", overrun, 0);

    // T4: completion under host lock drops the frame
    bus.host_lock = 1'b1;
    trigger();
    strobes(1024);
    flags("t4", 1, 1, 1, 3);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();
    check("t4_ovr_clr", overrun, 0);
    bus.host_lock = 1'b0; tick();
    check("t4_unlock_ready", bus.ready, 0);

    // T5 cont: lock falls in the completion cycle, ready must end up set
    trigger();
    strobes(1000);
    bus.host_lock = 1'b1;
    strobes(23);
    strobe(1'b1, 1'b0);
    check("t5c_pending", exp_q.size(), 0);
    flags("t5c", 0, 1, 0, 4);

    // T6: stable drops mid-frame
    trigger();
    strobes(300);
    cap_on = 1'b0;
    stable = 1'b0;
    tick();
    check("t6_abort", state_o, 0);
    check("t6_pending", exp_q.size(), 0);
    flags("t6", 0, 1, 0, 4);
    stable = 1'b1;
    tick();
    check("t6_rearm", state_o, 1);

    // Holdoff of 100 strobes; overrun set coincides with ovr_clr
    cfg_holdoff = 16'd100;
    trigger();
    strobes(1023);
    strobe(1'b0, 1'b1);
    flags("hold", 1, 1, 1, 5);
    check("hold_enter", state_o, 3);
    strobes(99);
    check("hold_99", state_o, 3);
    strobes(1);
    check("hold_100", state_o, 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();
    check("hold_ovr_clr", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
